// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-serial memory controller between instruction
// fetch and the load/store buffer. One op is outstanding at a time. LSB has
// priority, but a streak counter forces a fetch grant after LSB_STREAK_MAX
// consecutive LSB wins while fetch is waiting. Speculative ops hit by a
// pipeline clear are drained silently; committed stores always complete.
module mem_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int LSB_STREAK_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              clear,
   // fetch side
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_data,
   // load/store buffer side
   input  logic              lsb_req,
   input  logic              lsb_we,
   input  logic [ADDR_W-1:0] lsb_addr,
   input  logic [2:0]        lsb_len,
   input  logic [DATA_W-1:0] lsb_wdata,
   output logic              lsb_done,
   output logic [DATA_W-1:0] lsb_rdata,
   // memory controller side
   output logic              mc_start,
   output logic              mc_we,
   output logic [ADDR_W-1:0] mc_addr,
   output logic [2:0]        mc_len,
   output logic [DATA_W-1:0] mc_wdata,
   input  logic              mc_done,
   input  logic [DATA_W-1:0] mc_rdata
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] BUSY_IF = 2'd1;
   localparam logic [1:0] BUSY_LS = 2'd2;
   localparam logic [1:0] DRAIN   = 2'd3;

   localparam int            SW         = $clog2(LSB_STREAK_MAX + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(LSB_STREAK_MAX);

   logic [1:0]    state;
   logic [SW-1:0] streak;
   logic          if_eff, lsb_eff, grant_if, grant_ls;

   // Arbitration. A requester whose done pulse is showing this cycle has not
   // yet had a chance to drop its req, so it is not considered.
   always_comb begin
      if_eff   = if_req  & ~if_done;
      lsb_eff  = lsb_req & ~lsb_done;
      grant_ls = lsb_eff & (~if_eff | (streak < STREAK_MAX));
      grant_if = if_eff  & ~grant_ls;
   end

   // Issue / completion state machine; everything freezes while rdy is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         streak    <= '0;
         mc_start  <= 1'b0;
         mc_we     <= 1'b0;
         mc_addr   <= '0;
         mc_len    <= '0;
         mc_wdata  <= '0;
         if_done   <= 1'b0;
         if_data   <= '0;
         lsb_done  <= 1'b0;
         lsb_rdata <= '0;
      end else if (rdy) begin
         mc_start <= 1'b0;
         if_done  <= 1'b0;
         lsb_done <= 1'b0;
         case (state)
            IDLE: begin
               if (!clear) begin
                  if (grant_ls) begin
                     mc_start <= 1'b1;
                     mc_we    <= lsb_we;
                     mc_addr  <= lsb_addr;
                     mc_len   <= lsb_len;
                     mc_wdata <= lsb_wdata;
                     // streak only counts wins taken while fetch is waiting
                     if (!if_req)
                        streak <= '0;
                     else if (streak < STREAK_MAX)
                        streak <= streak + SW'(1);
                     state <= BUSY_LS;
                  end else if (grant_if) begin
                     mc_start <= 1'b1;
                     mc_we    <= 1'b0;
                     mc_addr  <= if_addr;
                     mc_len   <= 3'd4;
                     mc_wdata <= '0;
                     streak   <= '0;
                     state    <= BUSY_IF;
                  end
               end
            end
            BUSY_IF: begin
               if (mc_done) begin
                  // a clear landing with mc_done squashes the response
                  if (!clear) begin
                     if_data <= mc_rdata;
                     if_done <= 1'b1;
                  end
                  state <= IDLE;
               end else if (clear) begin
                  state <= DRAIN;
               end
            end
            BUSY_LS: begin
               if (mc_we) begin
                  // committed store: clear cannot cancel it
                  if (mc_done) begin
                     lsb_done  <= 1'b1;
                     lsb_rdata <= '0;
                     state     <= IDLE;
                  end
               end else if (mc_done) begin
                  if (!clear) begin
                     lsb_rdata <= mc_rdata;
                     lsb_done  <= 1'b1;
                  end
                  state <= IDLE;
               end else if (clear) begin
                  state <= DRAIN;
               end
            end
            default: begin
               // DRAIN: wait out the cancelled op, no response to anyone
               if (mc_done) state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Expected controller issues and requester
// responses are queued when stimulus is driven and popped when the DUT
// pulses mc_start / if_done / lsb_done.
module tb_mem_arbiter;

   localparam logic [1:0] S_IDLE = 2'd0, S_BIF = 2'd1, S_BLS = 2'd2, S_DRAIN = 2'd3;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [2:0]  len;
      logic [31:0] wdata;
   } iss_t;

   typedef struct {
      bit          is_if;
      logic [31:0] data;
   } rsp_t;

   logic        clk, rst, rdy, clear;
   logic        if_req, if_done, lsb_req, lsb_we, lsb_done;
   logic [31:0] if_addr, if_data, lsb_addr, lsb_wdata, lsb_rdata;
   logic [2:0]  lsb_len, mc_len;
   logic        mc_start, mc_we, mc_done;
   logic [31:0] mc_addr, mc_wdata, mc_rdata;

   iss_t iss_q[$];
   rsp_t rsp_q[$];
   iss_t cur;
   int   n_cmp = 0, n_err = 0, n_start = 0, li = 0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LSB_STREAK_MAX(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
      .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
      .mc_start(mc_start), .mc_we(mc_we), .mc_addr(mc_addr), .mc_len(mc_len),
      .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic iss_t mk_iss(logic we, logic [31:0] a, logic [2:0] l, logic [31:0] w);
      iss_t t;
      t.we = we; t.addr = a; t.len = l; t.wdata = w;
      return t;
   endfunction

   function automatic rsp_t mk_rsp(bit is_if, logic [31:0] d);
      rsp_t t;
      t.is_if = is_if; t.data = d;
      return t;
   endfunction

   // Pop and compare scoreboard entries against any pulse just produced.
   task automatic mon();
      rsp_t r;
      if (mc_start) begin
         n_start++;
         chk("start_expected", 64'(iss_q.size() != 0), 1);
         if (iss_q.size() != 0) begin
            cur = iss_q.pop_front();
            chk("mc_we", mc_we, cur.we);
            chk("mc_addr", mc_addr, cur.addr);
            chk("mc_len", mc_len, cur.len);
            chk("mc_wdata", mc_wdata, cur.wdata);
         end
      end
      if (if_done || lsb_done) begin
         chk("done_expected", 64'(rsp_q.size() != 0), 1);
         chk("single_done", 64'(if_done && lsb_done), 0);
         if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            chk("done_who_if", if_done, r.is_if);
            if (if_done) chk("if_data", if_data, r.data);
            else         chk("lsb_rdata", lsb_rdata, r.data);
         end
      end
   endtask

   // One clock; outputs sampled 1 time unit after the edge. Pulses are only
   // scored when the edge actually advanced the DUT.
   task automatic tick();
      bit s;
      s = rdy && !rst;
      @(posedge clk);
      #1;
      if (s) mon();
   endtask

   task automatic wait_start(input int max);
      int k;
      k = 0;
      do begin
         tick();
         k++;
      end while (!mc_start && k < max);
      chk("start_seen", mc_start, 1);
   endtask

   // Controller model: mc_done arrives lat cycles after the observed mc_start.
   task automatic finish_op(input int lat, input logic [31:0] d);
      repeat (lat - 1) begin
         tick();
         chk("mc_addr_stable", mc_addr, cur.addr);
      end
      mc_done = 1'b1; mc_rdata = d;
      tick();
      mc_done = 1'b0; mc_rdata = '0;
   endtask

   initial begin
      bit isif;
      rst = 1; rdy = 1; clear = 0;
      if_req = 0; if_addr = 0;
      lsb_req = 0; lsb_we = 0; lsb_addr = 0; lsb_len = 0; lsb_wdata = 0;
      mc_done = 0; mc_rdata = 0;
      repeat (2) tick();
      rst = 0;
      tick();
      chk("rst_state", dut.state, S_IDLE);
      chk("rst_streak", dut.streak, 0);
      chk("rst_mc_start", mc_start, 0);
      chk("rst_mc_addr", mc_addr, 0);
      chk("rst_mc_len", mc_len, 0);
      chk("rst_if_data", if_data, 0);
      chk("rst_lsb_rdata", lsb_rdata, 0);

      // fetch only
      if_req = 1; if_addr = 32'h1000;
      iss_q.push_back(mk_iss(0, 32'h1000, 4, 0));
      rsp_q.push_back(mk_rsp(1, 32'hDEADBEEF));
      wait_start(4);
      finish_op(6, 32'hDEADBEEF);
      chk("t1_if_done", if_done, 1);
      if_req = 0;
      repeat (3) tick();
      chk("t1_if_done_low", if_done, 0);
      chk("t1_if_data_hold", if_data, 32'hDEADBEEF);
      chk("t1_one_start", n_start, 1);

      // simultaneous: LSB first, fetch issued at mc_done+2
      if_req = 1; if_addr = 32'h2000;
      lsb_req = 1; lsb_we = 0; lsb_addr = 32'h20; lsb_len = 2; lsb_wdata = 0;
      iss_q.push_back(mk_iss(0, 32'h20, 2, 0));
      iss_q.push_back(mk_iss(0, 32'h2000, 4, 0));
      rsp_q.push_back(mk_rsp(0, 32'h0000A5A5));
      rsp_q.push_back(mk_rsp(1, 32'h11112222));
      wait_start(4);
      chk("t2_lsb_first", mc_addr, 32'h20);
      finish_op(3, 32'h0000A5A5);
      chk("t2_lsb_done", lsb_done, 1);
      lsb_req = 0;
      tick();
      chk("t2_if_at_m2", mc_start, 1);
      finish_op(2, 32'h11112222);
      if_req = 0;
      tick();

      // clear during a load: drained, no response, lsb_rdata holds
      lsb_req = 1; lsb_we = 0; lsb_addr = 32'h50; lsb_len = 4;
      iss_q.push_back(mk_iss(0, 32'h50, 4, 0));
      wait_start(4);
      tick();
      clear = 1;
      tick();
      clear = 0; lsb_req = 0;
      chk("t4_drain", dut.state, S_DRAIN);
      tick();
      mc_done = 1; mc_rdata = 32'h77777777;
      tick();
      mc_done = 0; mc_rdata = 0;
      chk("t4_idle", dut.state, S_IDLE);
      chk("t4_no_done", lsb_done, 0);
      chk("t4_rdata_hold", lsb_rdata, 32'h0000A5A5);
      tick();

      // clear during a store: store completes, lsb_rdata cleared
      lsb_req = 1; lsb_we = 1; lsb_addr = 32'h30; lsb_len = 4; lsb_wdata = 32'h12345678;
      iss_q.push_back(mk_iss(1, 32'h30, 4, 32'h12345678));
      rsp_q.push_back(mk_rsp(0, 32'h0));
      wait_start(4);
      tick();
      clear = 1;
      tick();
      clear = 0;
      chk("t5_busy_ls", dut.state, S_BLS);
      chk("t5_wdata_hold", mc_wdata, 32'h12345678);
      chk("t5_addr_hold", mc_addr, 32'h30);
      mc_done = 1; mc_rdata = 32'hCAFE;
      tick();
      mc_done = 0; mc_rdata = 0;
      chk("t5_lsb_done", lsb_done, 1);
      lsb_req = 0;
      tick();

      // starvation: LSB x4, IF, LSB x4, IF. A clear in the cycle of each
      // lsb_done keeps both requesters eligible at the next arbitration.
      if_req = 1; if_addr = 32'h3000;
      lsb_req = 1; lsb_we = 1; lsb_len = 1;
      lsb_addr = 32'h40; lsb_wdata = 32'hA000;
      for (int g = 0; g < 10; g++) begin
         isif = (g == 4) || (g == 9);
         if (isif) begin
            iss_q.push_back(mk_iss(0, 32'h3000, 4, 0));
            rsp_q.push_back(mk_rsp(1, 32'h30000000 + g));
         end else begin
            iss_q.push_back(mk_iss(1, 32'h40 + li, 1, 32'hA000 + li));
            rsp_q.push_back(mk_rsp(0, 32'h0));
         end
         wait_start(4);
         if (isif) chk("t3_streak_reset", dut.streak, 0);
         finish_op(2, isif ? 32'h30000000 + g : 32'hFFFFFFFF);
         if (!isif) begin
            li++;
            lsb_addr = 32'h40 + li; lsb_wdata = 32'hA000 + li;
            clear = 1;
            tick();
            clear = 0;
         end else if (g == 9) begin
            lsb_req = 0; if_req = 0;
         end
      end
      tick();

      // rdy low while busy: outputs (including the start pulse) freeze and a
      // frozen mc_done is not acted on until rdy returns
      if_req = 1; if_addr = 32'h6000;
      iss_q.push_back(mk_iss(0, 32'h6000, 4, 0));
      rsp_q.push_back(mk_rsp(1, 32'h600D));
      wait_start(4);
      rdy = 0;
      tick();
      chk("t6_frz_start", mc_start, 1);
      tick();
      mc_done = 1; mc_rdata = 32'h600D;
      tick();
      chk("t6_frz_no_done", if_done, 0);
      chk("t6_frz_state", dut.state, S_BIF);
      chk("t6_frz_addr", mc_addr, 32'h6000);
      rdy = 1;
      tick();
      mc_done = 0; mc_rdata = 0;
      chk("t6_done_after_rdy", if_done, 1);
      chk("t6_start_low", mc_start, 0);

      // reset mid-op (with rdy low) clears everything
      if_addr = 32'h7000;
      lsb_req = 1; lsb_we = 0; lsb_addr = 32'h70; lsb_len = 4; lsb_wdata = 32'h55;
      iss_q.push_back(mk_iss(0, 32'h70, 4, 32'h55));
      wait_start(4);
      chk("t6_streak_one", dut.streak, 1);
      tick();
      rdy = 0; rst = 1;
      tick();
      rst = 0; rdy = 1; lsb_req = 0; if_req = 0;
      chk("t6_rst_state", dut.state, S_IDLE);
      chk("t6_rst_streak", dut.streak, 0);
      chk("t6_rst_mc_addr", mc_addr, 0);
      chk("t6_rst_mc_len", mc_len, 0);
      chk("t6_rst_mc_wdata", mc_wdata, 0);
      chk("t6_rst_if_data", if_data, 0);
      chk("t6_rst_lsb_rdata", lsb_rdata, 0);
      repeat (3) tick();
      chk("end_no_start", mc_start, 0);
      chk("iss_q_empty", iss_q.size(), 0);
      chk("rsp_q_empty", rsp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
